// File: rtl/clk_switch_ctrl.sv
// rtl/clk_switch_ctrl.sv - break-before-make sequencer for an N-input glitch-free clock switch
//
// Purpose: synchronises an asynchronous source select and per-source enable
// acknowledges. A source change turns every enable off and waits for every ack
// to drop. Only then does it move the mux select, enable the new source and
// wait for that source's ack. Also provides a forced all-off (halt) mode,
// invalid-select flagging and a wait-phase timeout flag.
//
// Ports:
//   clk            control clock, rising edge
//   clk_res        asynchronous active-high reset
//   sel            requested source (asynchronous level)
//   force_off      synchronous level, 1 = hold every source off
//   en_ack         per-source enable-active status (asynchronous)
//   clk_en         per-source enable request, one-hot or zero
//   clk_selection  clock mux select
//   busy           high outside RUN and HALT
//   switch_done    one-cycle pulse when a switch completes
//   sel_err        sticky, a stable out-of-range sel was seen in RUN
//   timeout_err    a wait phase ran for TIMEOUT cycles or more
module clk_switch_ctrl #(
  parameter int NUM_CLK     = 4,
  parameter int SEL_W       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int RESET_SEL   = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               clk_res,
  input  logic [SEL_W-1:0]   sel,
  input  logic               force_off,
  input  logic [NUM_CLK-1:0] en_ack,
  output logic [NUM_CLK-1:0] clk_en,
  output logic [SEL_W-1:0]   clk_selection,
  output logic               busy,
  output logic               switch_done,
  output logic               sel_err,
  output logic               timeout_err
);

  typedef enum logic [2:0] {RUN, OFF_WAIT, SWITCH, ON_WAIT, HALT} state_t;

  localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(RESET_SEL);

  function automatic logic [NUM_CLK-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = '0;
    for (int i = 0; i < NUM_CLK; i++) begin
      if (idx == SEL_W'(i)) onehot[i] = 1'b1;
    end
  endfunction

  // Synchroniser chains are flat vectors; the newest sample enters at the LSB end.
  logic [SYNC_STAGES*SEL_W-1:0]   sel_sync_q, sel_sync_d;
  logic [SYNC_STAGES*NUM_CLK-1:0] ack_sync_q, ack_sync_d;
  logic [SEL_W-1:0]   sel_dly_q, sel_dly_d;
  logic [SEL_W-1:0]   sel_s;
  logic [NUM_CLK-1:0] ack_s;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   selection_q, selection_d;
  logic [NUM_CLK-1:0] clk_en_q, clk_en_d;
  logic               busy_q, busy_d;
  logic               switch_done_q, switch_done_d;
  logic               sel_err_q, sel_err_d;
  logic               timeout_err_q, timeout_err_d;
  logic [15:0]        tmo_cnt_q, tmo_cnt_d;

  logic sel_valid, sel_stable, in_wait;

  assign sel_s = sel_sync_q[SYNC_STAGES*SEL_W-1 -: SEL_W];
  assign ack_s = ack_sync_q[SYNC_STAGES*NUM_CLK-1 -: NUM_CLK];

  always_comb begin
    sel_sync_d = {sel_sync_q[(SYNC_STAGES-1)*SEL_W-1:0], sel};
    ack_sync_d = {ack_sync_q[(SYNC_STAGES-1)*NUM_CLK-1:0], en_ack};
    sel_dly_d  = sel_s;

    state_d       = state_q;
    selection_d   = selection_q;
    sel_err_d     = sel_err_q;
    timeout_err_d = timeout_err_q;
    tmo_cnt_d     = tmo_cnt_q;

    sel_valid  = int'(sel_s) < NUM_CLK;
    sel_stable = (sel_s == sel_dly_q);
    in_wait    = (state_q == OFF_WAIT) || (state_q == ON_WAIT);

    case (state_q)
      RUN: begin
        if (force_off) begin
          state_d = OFF_WAIT;
        end else if (sel_stable) begin
          if (!sel_valid) sel_err_d = 1'b1;
          else if (sel_s != selection_q) state_d = OFF_WAIT;
        end
      end
      OFF_WAIT: begin
        if (ack_s == '0) state_d = force_off ? HALT : SWITCH;
      end
      SWITCH: begin
        // Takes whatever valid select is current, absorbing changes made while off.
        if (sel_valid) selection_d = sel_s;
        state_d = ON_WAIT;
      end
      ON_WAIT: begin
        if ((ack_s & onehot(selection_q)) != '0) state_d = RUN;
        else if (force_off) state_d = OFF_WAIT;
      end
      HALT: begin
        if (!force_off) state_d = SWITCH;
      end
      default: state_d = RUN;
    endcase

    if (state_d != state_q) begin
      tmo_cnt_d = '0;
    end else if (in_wait && (tmo_cnt_q != 16'hFFFF)) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end

    // The error only flags a slow phase; the sequence still waits for the ack.
    if ((state_d != state_q) && ((state_d == RUN) || (state_d == HALT))) begin
      timeout_err_d = 1'b0;
    end else if (in_wait && (state_d == state_q) && (int'(tmo_cnt_d) >= TIMEOUT)) begin
      timeout_err_d = 1'b1;
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    clk_en_d      = ((state_d == RUN) || (state_d == ON_WAIT)) ? onehot(selection_d) : '0;
    busy_d        = !((state_d == RUN) || (state_d == HALT));
    switch_done_d = (state_q == ON_WAIT) && (state_d == RUN);
  end

  always_ff @(posedge clk or posedge clk_res) begin
    if (clk_res) begin
      sel_sync_q    <= {SYNC_STAGES{RST_SEL}};
      ack_sync_q    <= '0;
      sel_dly_q     <= RST_SEL;
      state_q       <= RUN;
      selection_q   <= RST_SEL;
      clk_en_q      <= onehot(RST_SEL);
      busy_q        <= 1'b0;
      switch_done_q <= 1'b0;
      sel_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      sel_sync_q    <= sel_sync_d;
      ack_sync_q    <= ack_sync_d;
      sel_dly_q     <= sel_dly_d;
      state_q       <= state_d;
      selection_q   <= selection_d;
      clk_en_q      <= clk_en_d;
      busy_q        <= busy_d;
      switch_done_q <= switch_done_d;
      sel_err_q     <= sel_err_d;
      timeout_err_q <= timeout_err_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign clk_en        = clk_en_q;
  assign clk_selection = selection_q;
  assign busy          = busy_q;
  assign switch_done   = switch_done_q;
  assign sel_err       = sel_err_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb/tb_clk_switch_ctrl.sv - self-checking bench for clk_switch_ctrl (4-source and 3-source instances)
module tb_clk_switch_ctrl;

  logic       clk = 1'b0;
  logic       clk_res;
  logic [1:0] sel_a, sel_b;
  logic       force_off_a, force_off_b;
  logic [3:0] en_ack_a, clk_en_a;
  logic [2:0] en_ack_b, clk_en_b;
  logic [1:0] clk_selection_a, clk_selection_b;
  logic       busy_a, busy_b, switch_done_a, switch_done_b;
  logic       sel_err_a, sel_err_b, timeout_err_a, timeout_err_b;

  int n_checks = 0;
  int n_errors = 0;

  // Source-domain model: each ack follows its enable three cycles later.
  logic [3:0] hist_a [3];
  logic [2:0] hist_b [3];
  logic [3:0] stuck_a;

  int         done_a, done_b;
  logic       busy_seen_a, busy_seen_b;
  logic [1:0] prev_selection_a, prev_selection_b;
  logic [3:0] prev_en_a;
  logic [2:0] prev_en_b;
  logic       prev_rst;
  int         last_a, last_b;

  always #5 clk = ~clk;

  clk_switch_ctrl #(.NUM_CLK(4), .SEL_W(2), .SYNC_STAGES(2), .RESET_SEL(0), .TIMEOUT(8)) dut_a (
    .clk(clk), .clk_res(clk_res), .sel(sel_a), .force_off(force_off_a), .en_ack(en_ack_a),
    .clk_en(clk_en_a), .clk_selection(clk_selection_a), .busy(busy_a), .switch_done(switch_done_a),
    .sel_err(sel_err_a), .timeout_err(timeout_err_a)
  );

  clk_switch_ctrl #(.NUM_CLK(3), .SEL_W(2), .SYNC_STAGES(2), .RESET_SEL(0), .TIMEOUT(8)) dut_b (
    .clk(clk), .clk_res(clk_res), .sel(sel_b), .force_off(force_off_b), .en_ack(en_ack_b),
    .clk_en(clk_en_b), .clk_selection(clk_selection_b), .busy(busy_b), .switch_done(switch_done_b),
    .sel_err(sel_err_b), .timeout_err(timeout_err_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (switch_done_a) done_a++;
    if (switch_done_b) done_b++;
    busy_seen_a = busy_seen_a | busy_a;
    busy_seen_b = busy_seen_b | busy_b;
    check_eq("onehot_a", {31'd0, $countones(clk_en_a) < 2}, 32'd1);
    check_eq("onehot_b", {31'd0, $countones(clk_en_b) < 2}, 32'd1);
    // The mux select may only move while every enable is off.
    if (!clk_res && !prev_rst && (clk_selection_a != prev_selection_a))
      check_eq("bbm_a", {28'd0, prev_en_a}, 32'd0);
    if (!clk_res && !prev_rst && (clk_selection_b != prev_selection_b))
      check_eq("bbm_b", {29'd0, prev_en_b}, 32'd0);
    prev_selection_a = clk_selection_a;
    prev_selection_b = clk_selection_b;
    prev_en_a = clk_en_a;
    prev_en_b = clk_en_b;
    prev_rst  = clk_res;
    en_ack_a  = hist_a[2] & ~stuck_a;
    en_ack_b  = hist_b[2];
    hist_a[2] = hist_a[1]; hist_a[1] = hist_a[0]; hist_a[0] = clk_en_a;
    hist_b[2] = hist_b[1]; hist_b[1] = hist_b[0]; hist_b[0] = clk_en_b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk_res = 1'b1;
    sel_a = 2'd0; sel_b = 2'd0;
    force_off_a = 1'b0; force_off_b = 1'b0;
    en_ack_a = '0; en_ack_b = '0; stuck_a = '0;
    for (int i = 0; i < 3; i++) begin
      hist_a[i] = '0;
      hist_b[i] = '0;
    end
    done_a = 0; done_b = 0; busy_seen_a = 1'b0; busy_seen_b = 1'b0;
    prev_selection_a = '0; prev_selection_b = '0; prev_en_a = '0; prev_en_b = '0; prev_rst = 1'b1;

    // Reset values, during and after reset
    tick(); tick();
    check_eq("rst_en_a", clk_en_a, 4'b0001);
    check_eq("rst_sel_a", clk_selection_a, 0);
    check_eq("rst_busy_a", busy_a, 0);
    check_eq("rst_flags_a", {sel_err_a, timeout_err_a, switch_done_a}, 0);
    clk_res = 1'b0;
    repeat (5) tick();
    check_eq("post_rst_en_a", clk_en_a, 4'b0001);
    check_eq("post_rst_busy_a", busy_a, 0);
    check_eq("post_rst_en_b", clk_en_b, 3'b001);

    // One-cycle select glitch must not start a switch
    busy_seen_a = 1'b0; done_a = 0;
    sel_a = 2'd1; tick(); sel_a = 2'd0;
    repeat (20) tick();
    check_eq("glitch_busy_a", busy_seen_a, 0);
    check_eq("glitch_en_a", clk_en_a, 4'b0001);
    check_eq("glitch_done_a", done_a, 0);

    // 0 -> 2
    sel_a = 2'd2; done_a = 0;
    repeat (4) tick();
    check_eq("sw02_en_off", clk_en_a, 4'b0000);
    check_eq("sw02_sel_held", clk_selection_a, 0);
    repeat (40) tick();
    check_eq("sw02_sel", clk_selection_a, 2);
    check_eq("sw02_en", clk_en_a, 4'b0100);
    check_eq("sw02_done", done_a, 1);
    check_eq("sw02_busy", busy_a, 0);

    // Back to 0, then 0 -> 1 redirected to 3 while off
    sel_a = 2'd0;
    repeat (40) tick();
    check_eq("sw20_sel", clk_selection_a, 0);
    sel_a = 2'd1;
    for (int i = 0; i < 10 && !busy_a; i++) tick();
    check_eq("enter_off_wait", busy_a, 1);
    sel_a = 2'd3; done_a = 0;
    repeat (40) tick();
    check_eq("redir_sel", clk_selection_a, 3);
    check_eq("redir_en", clk_en_a, 4'b1000);
    check_eq("redir_done", done_a, 1);

    // Halt from source 1, then a stuck ack forces a timeout
    sel_a = 2'd1;
    repeat (40) tick();
    check_eq("pre_halt_sel", clk_selection_a, 1);
    force_off_a = 1'b1;
    repeat (15) tick();
    check_eq("halt_en", clk_en_a, 4'b0000);
    check_eq("halt_busy", busy_a, 0);
    check_eq("halt_sel", clk_selection_a, 1);
    stuck_a = 4'b0010; force_off_a = 1'b0;
    repeat (4) tick();
    check_eq("tmo_early", timeout_err_a, 0);
    check_eq("tmo_early_busy", busy_a, 1);
    repeat (16) tick();
    check_eq("tmo_set", timeout_err_a, 1);
    check_eq("tmo_busy", busy_a, 1);
    check_eq("tmo_en", clk_en_a, 4'b0010);
    stuck_a = 4'b0000; done_a = 0;
    repeat (20) tick();
    check_eq("tmo_done", done_a, 1);
    check_eq("tmo_clear", timeout_err_a, 0);
    check_eq("tmo_busy_end", busy_a, 0);

    // Reset in the middle of a switch
    sel_a = 2'd2;
    repeat (6) tick();
    clk_res = 1'b1;
    #1;
    check_eq("midrst_en", clk_en_a, 4'b0001);
    check_eq("midrst_sel", clk_selection_a, 0);
    check_eq("midrst_busy", busy_a, 0);
    sel_a = 2'd0;
    tick(); tick();
    clk_res = 1'b0; busy_seen_a = 1'b0;
    repeat (20) tick();
    check_eq("midrst_idle", busy_seen_a, 0);

    // Out-of-range select on the 3-source instance
    sel_b = 2'd3; busy_seen_b = 1'b0;
    repeat (10) tick();
    check_eq("selerr_set", sel_err_b, 1);
    check_eq("selerr_en", clk_en_b, 3'b001);
    check_eq("selerr_busy", busy_seen_b, 0);
    sel_b = 2'd2; done_b = 0;
    repeat (40) tick();
    check_eq("selerr_sticky", sel_err_b, 1);
    check_eq("b_sel", clk_selection_b, 2);
    check_eq("b_en", clk_en_b, 3'b100);
    check_eq("b_done", done_b, 1);

    // Random select sequences; the final settled select must equal the last request
    for (int r = 0; r < 4; r++) begin
      for (int it = 0; it < 12; it++) begin
        last_a = int'($urandom_range(0, 3));
        last_b = int'($urandom_range(0, 2));
        sel_a = 2'(last_a);
        sel_b = 2'(last_b);
        repeat ($urandom_range(1, 12)) tick();
      end
      repeat (60) tick();
      check_eq("rnd_sel_a", clk_selection_a, last_a);
      check_eq("rnd_en_a", clk_en_a, 32'd1 << last_a);
      check_eq("rnd_busy_a", busy_a, 0);
      check_eq("rnd_sel_b", clk_selection_b, last_b);
      check_eq("rnd_en_b", clk_en_b, 32'd1 << last_b);
      check_eq("rnd_flags", {sel_err_a, sel_err_b, timeout_err_a, timeout_err_b}, 4'b0100);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
- Control-domain sequencer for an N-input glitch-free clock switch, generalised from the 2:1 case to NUM_CLK sources.
- Synchronises an asynchronous select and per-source enable acknowledges, then runs the break-before-make sequence: all enables off, all acks low, change mux select, enable target, target ack high.
- Adds invalid-select rejection, a forced all-off (halt) mode, a per-phase timeout flag and a switch-done pulse.
- Per-domain enable synchronisers, clock gates and the final clock mux sit outside this block.

Parameters:
- NUM_CLK, 4, number of selectable source clocks (2..16).
- SEL_W, 2, width of sel / clk_selection; 2**SEL_W >= NUM_CLK.
- SYNC_STAGES, 2, flop stages on sel and each en_ack bit (>= 2).
- RESET_SEL, 0, source selected and enabled out of reset (< NUM_CLK).
- TIMEOUT, 255, clk cycles allowed in OFF_WAIT or ON_WAIT before timeout_err (1..2**16-1).

Ports:
- clk  input  1  control clock; all flops on rising edge.
- clk_res  input  1  asynchronous, active-high reset.
- sel  input  SEL_W  requested source; asynchronous level.
- force_off  input  1  synchronous level; 1 = hold all sources off.
- en_ack  input  NUM_CLK  per-source "enable active" status from each source domain; asynchronous.
- clk_en  output  NUM_CLK  per-source enable request; one-hot or all-zero.
- clk_selection  output  SEL_W  final clock mux select.
- busy  output  1  high in every state except RUN and HALT.
- switch_done  output  1  one-cycle pulse on ON_WAIT -> RUN.
- sel_err  output  1  sticky; set on a stable out-of-range sel.
- timeout_err  output  1  set when a wait phase exceeds TIMEOUT.

Behaviour:
- Reset values:
  - state = RUN; clk_selection = target = RESET_SEL; clk_en = onehot(RESET_SEL).
  - busy, switch_done, sel_err and timeout_err = 0.
  - sel sync chain = RESET_SEL; en_ack sync chain = 0; timeout counter = 0.
- Synchronisation:
  - sel_s = sel after SYNC_STAGES flops; sel_d = sel_s delayed by one more cycle.
  - ack_s = en_ack after SYNC_STAGES flops.
  - sel is "stable" when sel_s == sel_d.
- RUN:
  - clk_en = onehot(clk_selection).
  - force_off = 1: OFF_WAIT, target unchanged.
  - Else, stable sel_s != clk_selection and sel_s < NUM_CLK: OFF_WAIT.
  - Stable sel_s >= NUM_CLK: set sel_err, stay in RUN. sel_err clears only on reset.
- OFF_WAIT:
  - clk_en = 0.
  - ack_s == 0 on all bits: go to HALT if force_off = 1, else SWITCH.
- SWITCH (exactly one cycle):
  - clk_en = 0.
  - target and clk_selection load the current sel_s if it is valid; otherwise they keep the old value.
  - Next state is ON_WAIT.
- ON_WAIT:
  - clk_en = onehot(clk_selection).
  - ack_s[clk_selection] == 1: RUN, with switch_done = 1 for that cycle.
  - force_off = 1: OFF_WAIT.
- HALT:
  - clk_en = 0; busy = 0.
  - force_off = 0: SWITCH, which picks up the latest valid sel.
- Select changes mid-sequence:
  - A sel change in OFF_WAIT is absorbed at SWITCH.
  - A sel change in ON_WAIT completes the current switch, then RUN starts a new one.
  - sel returning to the old value during OFF_WAIT still completes the full off/on cycle.
- Timeout:
  - 16-bit counter; cleared on every state change, increments in OFF_WAIT and ON_WAIT.
  - When the counter reaches TIMEOUT: set timeout_err and keep waiting. The block never proceeds without acks.
  - timeout_err clears on the next entry to RUN or HALT.
- Invariants:
  - clk_selection changes only in SWITCH, i.e. only while clk_en == 0 and all ack_s == 0 were observed.
  - clk_en never has more than one bit set.
- Reset mid-operation (assertion in any state) returns immediately to the reset values.

Test Plan:
- Reset with RESET_SEL=0, NUM_CLK=4, acks model 3-cycle latency:
  - Required: clk_en=4'b0001, clk_selection=0, busy=0 through and after release.
- sel 0->2, acks follow clk_en after 3 cycles:
  - Required: clk_en to 0 within SYNC_STAGES+2 cycles; clk_selection=2 only after ack_s==0.
  - Then clk_en=4'b0100; switch_done one pulse; busy=0 after.
- sel glitches 0->1->0, each value held for 1 cycle:
  - Required: no OFF_WAIT entry; clk_en stays 4'b0001.
- sel=3 during OFF_WAIT of a 0->1 switch:
  - Required: clk_selection=3; exactly one switch_done.
- sel=3 with NUM_CLK=3:
  - Required: sel_err=1 stays set, clk_en unchanged, busy=0.
- force_off pulse, then release with ack[1] held low and TIMEOUT=8:
  - force_off=1 from RUN on source 1 -> clk_en=0, HALT, busy=0.
  - force_off=0 with ack[1] stuck low -> timeout_err=1 after 8 ON_WAIT cycles.
  - Release the ack -> RUN, switch_done, timeout_err=0.
